// File: rtl/sr_muldiv_pkg.sv
// Shared definitions for the sequential RV32M multiply/divide unit:
// funct3 opcodes, FSM state type and operand-signedness helpers.
package sr_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/sr_muldiv_seq_step.sv
// One iteration of the datapath: a shift-add multiply step on {hi, multiplier}
// or a restoring-divide step on {rem, quo}.
module sr_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic                is_div,
  input  logic [2*XLEN-1:0]   acc_i,
  input  logic [XLEN-1:0]     mcand_i,
  output logic [2*XLEN-1:0]   acc_o
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] trial;

  assign add_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, (acc_i[0] ? mcand_i : '0)};
  // Borrow out of the (XLEN+1)-bit subtract means the shifted remainder is below the divisor.
  assign trial   = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]} - {1'b0, mcand_i};

  always_comb begin
    acc_o = acc_i;
    if (!is_div) begin
      acc_o = {add_sum, acc_i[XLEN-1:1]};
    end else if (!trial[XLEN]) begin
      acc_o = {trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {acc_i[2*XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sr_muldiv_seq.sv
// Iterative RV32M multiply/divide coprocessor with start/busy/done handshake;
// one result bit per cycle, 1-cycle fast path for divide-by-zero and overflow.
module sr_muldiv_seq
  import sr_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic [2*XLEN-1:0]   step_acc;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_s, rem_s, fin_result;
  logic                a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]     mag_a, mag_b;

  sr_muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (is_div(op_q)),
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .acc_o   (step_acc)
  );

  assign a_neg    = a_signed(op) & srcA[XLEN-1];
  assign b_neg    = b_signed(op) & srcB[XLEN-1];
  assign mag_a    = a_neg ? -srcA : srcA;
  assign mag_b    = b_neg ? -srcB : srcB;
  assign div_zero = is_div(op) && (srcB == '0);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (srcA == INT_MIN) && (srcB == '1);

  // Final sign fix is applied to the value the last step produces, so the result lands with DONE.
  assign prod_fix = qneg_q ? -step_acc : step_acc;
  assign quo_s    = qneg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
  assign rem_s    = rneg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];

  always_comb begin
    fin_result = prod_fix[2*XLEN-1:XLEN];
    if (is_div(op_q)) begin
      fin_result = op_q[1] ? rem_s : quo_s;
    end else if (op_q == OP_MUL) begin
      fin_result = prod_fix[XLEN-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          op_d = op;
          if (div_zero) begin
            result_d = op[1] ? srcA : '1;
            state_d  = ST_DONE;
          end else if (div_ovf) begin
            result_d = op[1] ? '0 : srcA;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_CALC;
            cnt_d   = CNT_W'(XLEN);
            acc_d   = {{XLEN{1'b0}}, (is_div(op) ? mag_a : mag_b)};
            mcand_d = is_div(op) ? mag_b : mag_a;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
          end
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = ST_DONE;
            result_d = fin_result;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == ST_CALC);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule
